// File: rtl/medidor_pkg.sv
// Shared types and default sizes for the period/high-time meter.
package medidor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEDINDO,
        ESTOURO
    } estado_t;

    localparam int MEDIDOR_WIDTH_DEF = 24;
    localparam int MEDIDOR_SYNC_DEF  = 2;

endpackage

// File: rtl/sincronizador_borda.sv
// Input synchronizer plus registered one-cycle rise/fall pulses.
// Fall detection only exists when MEDIDOR_ALTO_EN is defined.
module sincronizador_borda
    import medidor_pkg::*;
#(
    parameter int SYNC_STAGES = MEDIDOR_SYNC_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic entrada,
    output logic sobe,
    output logic desce
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ant_q, ant_d;
    logic                   sobe_q, sobe_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], entrada};
        ant_d  = sync_q[SYNC_STAGES-1];
        sobe_d = sync_q[SYNC_STAGES-1] & ~ant_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            ant_q  <= 1'b0;
            sobe_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            ant_q  <= ant_d;
            sobe_q <= sobe_d;
        end
    end

    assign sobe = sobe_q;

`ifdef MEDIDOR_ALTO_EN
    logic desce_q, desce_d;

    always_comb begin
        desce_d = ~sync_q[SYNC_STAGES-1] & ant_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            desce_q <= 1'b0;
        end else begin
            desce_q <= desce_d;
        end
    end

    assign desce = desce_q;
`else
    assign desce = 1'b0;
`endif

endmodule

// File: rtl/medidor_periodo.sv
// Period and high-time meter for a slow asynchronous square wave, with valid/ack output.
// Define MEDIDOR_ALTO_EN to build the high-time (alto) measurement; otherwise alto reads 0.
module medidor_periodo
    import medidor_pkg::*;
#(
    parameter int WIDTH       = MEDIDOR_WIDTH_DEF,
    parameter int SYNC_STAGES = MEDIDOR_SYNC_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             entrada,
    input  logic             limpar,
    input  logic             ack,
    output logic [WIDTH-1:0] periodo,
    output logic [WIDTH-1:0] alto,
    output logic             valido,
    output logic             estouro,
    output logic             perdido
);

    localparam logic [WIDTH-1:0] CONT_MAX = '1;

    function automatic logic [WIDTH-1:0] inc_sat(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] soma;
        soma = {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
        return soma[WIDTH] ? CONT_MAX : soma[WIDTH-1:0];
    endfunction

    logic sobe, desce;

    sincronizador_borda #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sinc (
        .clock  (clock),
        .reset_n(reset_n),
        .entrada(entrada),
        .sobe   (sobe),
        .desce  (desce)
    );

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] cont_q, cont_d;
    logic [WIDTH-1:0] periodo_q, periodo_d;
    logic             valido_q, valido_d;
    logic             estouro_q, estouro_d;
    logic             perdido_q, perdido_d;
    logic             gera_res, marca_estouro;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // A rise coinciding with saturation restarts the measurement without a result.
    always_comb begin
        estado_d = estado_q;
        if (limpar) begin
            estado_d = IDLE;
        end else begin
            case (estado_q)
                IDLE:    if (sobe) estado_d = MEDINDO;
                MEDINDO: if (cont_q == CONT_MAX && !sobe) estado_d = ESTOURO;
                ESTOURO: if (sobe) estado_d = MEDINDO;
                default: estado_d = IDLE;
            endcase
        end
    end

    always_comb begin
        gera_res      = (estado_q == MEDINDO) && sobe && (cont_q != CONT_MAX);
        marca_estouro = (estado_q == MEDINDO) && (cont_q == CONT_MAX);
    end

    always_comb begin
        cont_d    = cont_q;
        periodo_d = periodo_q;
        valido_d  = valido_q;
        estouro_d = estouro_q;
        perdido_d = perdido_q;
        if (limpar) begin
            cont_d    = '0;
            periodo_d = '0;
            valido_d  = 1'b0;
            estouro_d = 1'b0;
            perdido_d = 1'b0;
        end else begin
            if (sobe) begin
                cont_d = '0;
            end else if (cont_q != CONT_MAX) begin
                cont_d = inc_sat(cont_q);
            end
            if (gera_res) begin
                periodo_d = inc_sat(cont_q);
                valido_d  = 1'b1;
                if (valido_q && !ack) perdido_d = 1'b1;
            end else if (ack) begin
                valido_d = 1'b0;
            end
            if (marca_estouro) estouro_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_q    <= '0;
            periodo_q <= '0;
            valido_q  <= 1'b0;
            estouro_q <= 1'b0;
            perdido_q <= 1'b0;
        end else begin
            cont_q    <= cont_d;
            periodo_q <= periodo_d;
            valido_q  <= valido_d;
            estouro_q <= estouro_d;
            perdido_q <= perdido_d;
        end
    end

    assign periodo = periodo_q;
    assign valido  = valido_q;
    assign estouro = estouro_q;
    assign perdido = perdido_q;

`ifdef MEDIDOR_ALTO_EN
    logic [WIDTH-1:0] alto_q, alto_d;
    logic [WIDTH-1:0] alto_cap_q, alto_cap_d;

    // alto_cap restarts at each rise so a missing fall reports 0.
    always_comb begin
        alto_d     = alto_q;
        alto_cap_d = alto_cap_q;
        if (limpar) begin
            alto_d     = '0;
            alto_cap_d = '0;
        end else begin
            if (gera_res) alto_d = alto_cap_q;
            if (sobe) begin
                alto_cap_d = '0;
            end else if (estado_q == MEDINDO && desce) begin
                alto_cap_d = inc_sat(cont_q);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alto_q     <= '0;
            alto_cap_q <= '0;
        end else begin
            alto_q     <= alto_d;
            alto_cap_q <= alto_cap_d;
        end
    end

    assign alto = alto_q;
`else
    logic desce_unused;
    assign desce_unused = desce;
    assign alto         = '0;
`endif

endmodule

// File: doc/medidor_periodo.md
# medidor_periodo

Period and high-time meter for a slow square wave, the measuring end of the divider chain. It synchronizes an asynchronous input such as a divider output and counts `clock` cycles between consecutive rising edges. Each completed measurement is presented with a valid/ack handshake. Its intended use is on-board checking of divider outputs and external slow signals against the system clock.

## Interface
- `WIDTH`, default 24: counter and result width.
- `SYNC_STAGES`, default 2: synchronizer flip-flops on `entrada`; minimum 2.

- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `entrada` in 1: asynchronous square wave to measure.
- `limpar` in 1: synchronous clear.
- `ack` in 1: consumer has taken the current result.
- `periodo` out WIDTH: cycles between the last two rising edges.
- `alto` out WIDTH: cycles from the last rise to the following fall.
- `valido` out 1: result pending; held until `ack`.
- `estouro` out 1: sticky; period exceeded 2^WIDTH-1.
- `perdido` out 1: sticky; a result was overwritten before `ack`.

## Operation
- `entrada` passes through SYNC_STAGES flip-flops, then an edge detector producing one-cycle `sobe` and `desce` pulses.
- Counter `cont`:
  - cleared to 0 on `sobe`.
  - otherwise increments each cycle.
  - saturates at 2^WIDTH-1.
- States:
  - IDLE: wait for the first `sobe`, then go to MEDINDO. This edge produces no result.
  - MEDINDO:
    - On `desce`, capture `cont+1` into `alto_cap`.
    - On `sobe`, load `periodo` with `cont+1` and `alto` with `alto_cap`, set `valido`, and stay in MEDINDO.
    - If `cont` reaches 2^WIDTH-1, set `estouro` and go to ESTOURO.
  - ESTOURO: on `sobe`, restart counting in MEDINDO without producing a result.
- Handshake:
  - `ack` while `valido` is high clears `valido` on the next edge.
  - A new result while `valido=1` and `ack=0` overwrites the outputs and sets `perdido`.
  - `ack` in the same cycle as a new result: the new result wins, `valido` stays 1, `perdido` is not set.
- `limpar` forces IDLE and zeroes `cont`, `valido`, `estouro`, `perdido`, `periodo` and `alto`. The synchronizer is untouched. `limpar` has priority over edges and `ack`.
- Arithmetic: `cont+1` is computed at WIDTH+1 bits and clamped to 2^WIDTH-1.
- `alto` shows 0 if no fall occurred since the previous rise (`alto_cap` is cleared on `sobe`).

## Timing
- Reset (`reset_n` low, asynchronous):
  - Outputs `periodo`, `alto`, `valido`, `estouro` and `perdido` = 0.
  - Internal `cont` = 0, state IDLE, synchronizer = 0.
- Latency: `entrada` rise sampled at edge k; `sobe` is high during cycle k+SYNC_STAGES; `periodo` and `valido` update at edge k+SYNC_STAGES+1.
- For a stable period of P clocks, `periodo` = P exactly. A 50 % duty cycle gives `alto` = P/2.
- Pulses narrower than 1 clock may be missed; no glitch filtering is done.
- `reset_n` deassertion is synchronized externally; the block only requires it to be asynchronous on assertion.

## Configuration
- `MEDIDOR_ALTO_EN` defined:
  - `desce` detection, `alto_cap` and the `alto` register are built.
  - `alto` behaves as described above.
- `MEDIDOR_ALTO_EN` undefined:
  - That logic is removed.
  - `alto` is tied to 0.
  - All other behaviour, including `periodo` and the handshake, is unchanged.

## Structure
- Package `medidor_pkg`:
  - state enum `estado_t` {IDLE, MEDINDO, ESTOURO}.
  - constant `MEDIDOR_WIDTH_DEF = 24`.
  - constant `MEDIDOR_SYNC_DEF = 2`.
- Sub-module `sincronizador_borda`:
  - parameter SYNC_STAGES.
  - inputs `clock`, `reset_n`, `entrada`.
  - outputs `sobe`, `desce`.
- Top-level holds the FSM, counter, result registers and handshake.

## Test plan
- Reset, then a 10-clock square wave with 50 % duty: the second rise gives `periodo`=10, `alto`=5, `valido`=1, `estouro`=0.
- Same wave, `ack` pulsed after each result: `valido` falls one edge after each `ack`, `perdido` stays 0 over 5 periods.
- No `ack` across two results: second result `periodo`=10, `perdido`=1, `valido`=1; `limpar` returns all flags to 0.
- WIDTH=8, input held low for 300 clocks after the first rise: `estouro`=1 at cont=255, no `valido`. The next two rises of a 20-clock wave give `periodo`=20.
- `ack` in the same cycle as a new `sobe`: `valido` stays 1, `perdido`=0. `reset_n` low mid-period: all outputs 0 immediately, and the first rise after release gives no result.
- Build without `MEDIDOR_ALTO_EN`: a 10-clock wave gives `periodo`=10 and `alto`=0.
